// File: rtl/fifo_burst_scheduler.sv
// Read-side controller for the dual-clock PDMA FIFO: tracks fill level from the
// synchronized write pointer, requests PDMA bursts and sequences FIFO reads.
module fifo_burst_scheduler #(
  parameter int ADDRWIDTH = 3,
  parameter int BURST     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 flush,
  input  logic [ADDRWIDTH:0]   wptr_gray_sync,
  output logic [ADDRWIDTH:0]   rptr_gray,
  output logic [ADDRWIDTH-1:0] rd_addr,
  output logic                 fifo_re,
  output logic                 dma_req,
  output logic [ADDRWIDTH:0]   dma_len,
  input  logic                 dma_ack,
  input  logic                 dma_ready,
  output logic [ADDRWIDTH:0]   level,
  output logic                 empty,
  output logic                 busy
);

  localparam int PW = ADDRWIDTH + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  state_t          state, state_nxt;
  logic [PW-1:0]   wbin, rbin, rbin_inc, cnt, len_sel;
  logic [TW-1:0]   timer;
  logic            start, at_thresh;

  assign level     = wbin - rbin;
  assign empty     = (level == '0);
  assign busy      = (state != IDLE);
  assign rd_addr   = rbin[ADDRWIDTH-1:0];
  assign fifo_re   = (state == XFER) && dma_ready;
  assign rbin_inc  = rbin + 1'b1;
  assign at_thresh = (level >= PW'(BURST));
  assign len_sel   = at_thresh ? PW'(BURST) : level;
  // Flush and timeout only ever drain the residue; the threshold path caps at BURST.
  assign start     = (state == IDLE) && enable &&
                     (at_thresh || (!empty && ((timer == TW'(TIMEOUT)) || flush)));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ:  if (dma_ack) state_nxt = XFER;
      XFER: if (fifo_re && (cnt == PW'(1))) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      wbin      <= '0;
      rbin      <= '0;
      rptr_gray <= '0;
      cnt       <= '0;
      dma_req   <= 1'b0;
      dma_len   <= '0;
      timer     <= '0;
    end else begin
      state <= state_nxt;
      wbin  <= gray2bin(wptr_gray_sync);
      if (fifo_re) begin
        rbin      <= rbin_inc;
        rptr_gray <= bin2gray(rbin_inc);
        cnt       <= cnt - 1'b1;
      end
      if (start) begin
        dma_len <= len_sel;
        cnt     <= len_sel;
        dma_req <= 1'b1;
      end else if ((state == REQ) && dma_ack) begin
        dma_req <= 1'b0;
      end
      // Partial-fill timer only runs while idling on a non-empty sub-burst level.
      if ((state != IDLE) || start || empty || at_thresh)
        timer <= '0;
      else if (timer != TW'(TIMEOUT))
        timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// Bench for fifo_burst_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a cycle-level behavioural model of the scheduler.
module tb_fifo_burst_scheduler;

  localparam int AW   = 3;
  localparam int B    = 4;
  localparam int TO   = 8;
  localparam int MASK = (1 << (AW + 1)) - 1;
  localparam int DEP  = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable, flush, dma_ack, dma_ready;
  logic [AW:0]   wptr_gray_sync;
  logic [AW:0]   rptr_gray, dma_len, level;
  logic [AW-1:0] rd_addr;
  logic          fifo_re, dma_req, empty, busy;

  fifo_burst_scheduler #(.ADDRWIDTH(AW), .BURST(B), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .flush(flush),
    .wptr_gray_sync(wptr_gray_sync), .rptr_gray(rptr_gray), .rd_addr(rd_addr),
    .fifo_re(fifo_re), .dma_req(dma_req), .dma_len(dma_len), .dma_ack(dma_ack),
    .dma_ready(dma_ready), .level(level), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 requesting, 2 transferring, 3 finishing.
  int m_wb, m_rb, m_ph, m_tmr, m_rem, m_len;
  int wp;

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = AW; i >= 0; i--) b |= (((b >> (i + 1)) ^ (g >> i)) & 1) << i;
    return b;
  endfunction

  function automatic int m_level();
    return (m_wb - m_rb) & MASK;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wb = 0; m_rb = 0; m_ph = 0; m_tmr = 0; m_rem = 0; m_len = 0;
  endtask

  task automatic model_next();
    int l = m_level();
    int ph = m_ph;
    if (ph == 0) begin
      if (enable && (l >= B || (l != 0 && (m_tmr == TO || flush)))) begin
        m_len = (l < B) ? l : B;
        m_rem = m_len;
        m_ph  = 1;
        m_tmr = 0;
      end else if (l == 0 || l >= B) m_tmr = 0;
      else if (m_tmr < TO) m_tmr++;
    end else if (ph == 1) begin
      if (dma_ack) m_ph = 2;
    end else if (ph == 2) begin
      if (dma_ready) begin
        m_rb = (m_rb + 1) & MASK;
        m_rem--;
        if (m_rem == 0) m_ph = 3;
      end
    end else m_ph = 0;
    m_wb = g2b(int'(wptr_gray_sync));
  endtask

  task automatic compare();
    int l = m_level();
    chk("level", level, l);
    chk("empty", empty, l == 0);
    chk("busy", busy, m_ph != 0);
    chk("dma_req", dma_req, m_ph == 1);
    chk("dma_len", dma_len, m_len);
    chk("rptr_gray", rptr_gray, m_rb ^ (m_rb >> 1));
    chk("rd_addr", rd_addr, m_rb & (DEP - 1));
    chk("fifo_re", fifo_re, (m_ph == 2) && dma_ready);
  endtask

  task automatic tick();
    model_next();
    @(negedge clk);
    compare();
  endtask

  task automatic set_wp(input int v);
    wp = v & MASK;
    wptr_gray_sync = (AW+1)'(wp ^ (wp >> 1));
  endtask

  // Expects the scheduler to be requesting; acks and reads len words with ready held high.
  task automatic do_burst(input int len, input int addr0);
    chk("burst_len", dma_len, len);
    dma_ack = 1'b1; tick(); dma_ack = 1'b0;
    for (int i = 0; i < len; i++) begin
      dma_ready = 1'b1;
      #1;
      chk("burst_re", fifo_re, 1);
      chk("burst_addr", rd_addr, (addr0 + i) & (DEP - 1));
      tick();
    end
    dma_ready = 1'b0;
    chk("burst_done_busy", busy, 1);
    tick();
    chk("burst_idle", busy, 0);
  endtask

  task automatic drain();
    int n = 0;
    enable = 1'b1; flush = 1'b1; dma_ack = 1'b1; dma_ready = 1'b1;
    while ((m_level() != 0 || m_ph != 0 || m_wb != wp) && n < 200) begin
      tick(); n++;
    end
    if (n >= 200) begin
      errors++; checks++;
      $display("FAIL drain_timeout: level %0d phase %0d", m_level(), m_ph);
    end
    flush = 1'b0; dma_ack = 1'b0; dma_ready = 1'b0;
  endtask

  initial begin
    int pulses, room;
    rstn = 1'b0; enable = 1'b0; flush = 1'b0; dma_ack = 1'b0; dma_ready = 1'b0;
    set_wp(0);
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    compare();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_req", dma_req, 0);

    // Full burst: binary 4 arrives, request two edges later.
    enable = 1'b1;
    set_wp(4);
    chk("t1_gray_in", wptr_gray_sync, 4'b0110);
    tick();
    chk("t1_level", level, 4);
    chk("t1_req_early", dma_req, 0);
    tick();
    chk("t1_req", dma_req, 1);
    do_burst(4, 0);
    chk("t1_rptr", rptr_gray, 4'b0110);
    chk("t1_level_end", level, 0);

    // Timeout path, first with enable low.
    enable = 1'b0;
    set_wp(6);
    repeat (20) tick();
    chk("t2_no_req", dma_req, 0);
    chk("t2_level", level, 2);
    enable = 1'b1;
    tick();
    chk("t2_req", dma_req, 1);
    do_burst(2, 4);

    // Flush of a single residual word.
    set_wp(7);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_req", dma_req, 1);
    do_burst(1, 6);

    // Wrap: bring rbin to 13, then wbin to 1.
    set_wp(13);
    drain();
    chk("t4_rptr13", rptr_gray, 13 ^ (13 >> 1));
    set_wp(17);
    tick();
    chk("t4_level", level, 4);
    tick();
    do_burst(4, 5);
    chk("t4_rptr", rptr_gray, 4'b0001);

    // Backpressure on alternate cycles.
    set_wp(5);
    tick(); tick();
    dma_ack = 1'b1; tick(); dma_ack = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20 && m_ph == 2; c++) begin
      dma_ready = (c % 2 == 0);
      #1;
      if (fifo_re) pulses++;
      tick();
    end
    dma_ready = 1'b0;
    chk("t5_pulses", pulses, 4);
    tick();

    // Reset in the middle of a transfer.
    set_wp(9);
    tick(); tick();
    dma_ack = 1'b1; tick(); dma_ack = 1'b0;
    dma_ready = 1'b1; tick(); tick();
    rstn = 1'b0; dma_ready = 1'b0; set_wp(0);
    #1;
    model_reset();
    chk("t6_re", fifo_re, 0);
    chk("t6_req", dma_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_level", level, 0);
    chk("t6_empty", empty, 1);
    chk("t6_rptr", rptr_gray, 0);
    chk("t6_len", dma_len, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("t6_idle", busy, 0);

    // Random traffic with the write side never overfilling.
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom % 8) != 0;
      flush     = ($urandom % 16) == 0;
      dma_ack   = ($urandom % 3) == 0;
      dma_ready = $urandom % 2;
      if ($urandom % 3 == 0) begin
        room = DEP - ((wp - m_rb) & MASK);
        set_wp(wp + $urandom_range(0, room));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
